// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: empty-cell code, LFSR polynomial mask, generator
// FSM states and the seven shape codes.
package tetris_pkg;

  localparam int BLOCK_EMPTY = 0;

  // x^16+x^14+x^13+x^11+1 in right-shifting Galois form
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic {
    DRAW = 1'b0,
    FULL = 1'b1
  } gen_state_e;

  localparam int I = 1;
  localparam int O = 2;
  localparam int T = 3;
  localparam int S = 4;
  localparam int Z = 5;
  localparam int J = 6;
  localparam int L = 7;

endpackage

// File: rtl/tetris_lfsr.sv
// 16-bit Galois LFSR with synchronous load; also intended for garbage-row
// generation. A load takes priority over stepping.
module tetris_lfsr
  import tetris_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        en,
  output logic [15:0] value
);

  logic [15:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (en) begin
      value_d = (value_q >> 1) ^ (value_q[0] ? LFSR_MASK : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= SEED;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/piece_bag_generator.sv
// Piece generator: LFSR candidates filtered into a preview shift queue.
// Define PIECE_BAG_EN to enforce the 7-bag rule via a `used` shape mask.
module piece_bag_generator
  import tetris_pkg::*;
#(
  parameter int          NUM_SHAPES    = 7,
  parameter int          BLOCK_W       = 4,
  parameter int          PREVIEW_DEPTH = 3,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             next_req,
  input  logic                             seed_load,
  input  logic [15:0]                      seed,
  output logic [BLOCK_W-1:0]               next_block,
  output logic                             next_valid,
  output logic [PREVIEW_DEPTH*BLOCK_W-1:0] preview,
  output logic [3:0]                       count
);

  logic [15:0]        lfsr_value;
  logic [2:0]         cand;
  logic [BLOCK_W-1:0] cand_code;
  logic               cand_ok;
  logic               pop;
  logic               accept;
  logic [3:0]         wr_idx;
  logic               unused_lfsr_hi;

  logic [BLOCK_W-1:0] slots_q [PREVIEW_DEPTH];
  logic [BLOCK_W-1:0] slots_d [PREVIEW_DEPTH];
  logic [3:0]         count_q, count_d;
  gen_state_e         state_q, state_d;

`ifdef PIECE_BAG_EN
  localparam logic [7:0] FULL_BAG = 8'((1 << NUM_SHAPES) - 1);
  logic [7:0] used_q, used_d;
`endif

  tetris_lfsr #(.SEED(SEED)) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .load     (seed_load),
    .load_val ((seed == 16'h0000) ? SEED : seed),
    .en       (1'b1),
    .value    (lfsr_value)
  );

  assign cand           = lfsr_value[2:0];
  assign unused_lfsr_hi = ^lfsr_value[15:3];
  assign cand_code      = BLOCK_W'(32'(cand) + 1);

`ifdef PIECE_BAG_EN
  assign cand_ok = (32'(cand) < NUM_SHAPES) && !used_q[cand];
`else
  assign cand_ok = (32'(cand) < NUM_SHAPES);
`endif

  assign pop    = next_req && (count_q != 4'd0);
  assign accept = (state_q == DRAW) && cand_ok;
  // With a simultaneous pop the tail has moved one slot toward the head.
  assign wr_idx = pop ? (count_q - 4'd1) : count_q;

  always_comb begin
    slots_d = slots_q;
    count_d = count_q;
`ifdef PIECE_BAG_EN
    used_d  = used_q;
`endif
    if (seed_load) begin
      for (int i = 0; i < PREVIEW_DEPTH; i++) slots_d[i] = BLOCK_W'(BLOCK_EMPTY);
      count_d = 4'd0;
`ifdef PIECE_BAG_EN
      used_d  = 8'h00;
`endif
    end else begin
      if (pop) begin
        for (int i = 0; i < PREVIEW_DEPTH - 1; i++) slots_d[i] = slots_q[i+1];
        slots_d[PREVIEW_DEPTH-1] = BLOCK_W'(BLOCK_EMPTY);
      end
      for (int i = 0; i < PREVIEW_DEPTH; i++) begin
        if (accept && (4'(i) == wr_idx)) slots_d[i] = cand_code;
      end
      case ({accept, pop})
        2'b10:   count_d = count_q + 4'd1;
        2'b01:   count_d = count_q - 4'd1;
        default: count_d = count_q;
      endcase
`ifdef PIECE_BAG_EN
      if (accept) begin
        used_d = used_q | (8'h01 << cand);
        if (used_d == FULL_BAG) used_d = 8'h00;
      end
`endif
    end
    state_d = (count_d == 4'(PREVIEW_DEPTH)) ? FULL : DRAW;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PREVIEW_DEPTH; i++) slots_q[i] <= BLOCK_W'(BLOCK_EMPTY);
      count_q <= 4'd0;
      state_q <= DRAW;
`ifdef PIECE_BAG_EN
      used_q  <= 8'h00;
`endif
    end else begin
      slots_q <= slots_d;
      count_q <= count_d;
      state_q <= state_d;
`ifdef PIECE_BAG_EN
      used_q  <= used_d;
`endif
    end
  end

  always_comb begin
    preview = '0;
    for (int i = 0; i < PREVIEW_DEPTH; i++) preview[i*BLOCK_W +: BLOCK_W] = slots_q[i];
  end

  assign next_block = slots_q[0];
  assign next_valid = (count_q != 4'd0);
  assign count      = count_q;

endmodule
